// File: rtl/fifo_serial_tx_if.sv
// FIFO read-side port: empty flag, registered read data, pop strobe.
// master = the reader (drives fifo_read); slave = the FIFO.
interface fifo_serial_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_read;

  modport master (
    input  fifo_empty,
    input  fifo_rd_data,
    output fifo_read
  );

  modport slave (
    output fifo_empty,
    output fifo_rd_data,
    input  fifo_read
  );
endinterface

// File: rtl/fifo_serial_tx.sv
// Drains a FIFO and sends each word as start/LSB-first data/stop frame.
// Ports: clk, rst_, fifo (read port), tx_enable, tx_serial, tx_busy, word_count.
module fifo_serial_tx #(
  parameter int DATA_WIDTH   = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_,
  fifo_serial_tx_if.master fifo,
  input  logic       tx_enable,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic [7:0] word_count
);

  localparam int BW =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT =
    BW'(DATA_WIDTH - 1);
  localparam logic [7:0] DIV_LAST =
    8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, STOP
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [7:0]            div, div_n;
  logic [7:0]            count_n;
  logic                  bit_end;

  assign bit_end = (div == DIV_LAST);
  assign tx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      shift      <= '0;
      bit_cnt    <= '0;
      div        <= '0;
      word_count <= '0;
    end else begin
      shift      <= shift_n;
      bit_cnt    <= bit_n;
      div        <= div_n;
      word_count <= count_n;
    end
  end

  always_comb begin
    state_n        = state;
    shift_n        = shift;
    bit_n          = bit_cnt;
    div_n          = div;
    count_n        = word_count;
    fifo.fifo_read = 1'b0;
    tx_serial      = 1'b1;
    unique case (state)
      IDLE: begin
        if (tx_enable && !fifo.fifo_empty)
          state_n = POP;
      end
      POP: begin
        fifo.fifo_read = 1'b1;
        state_n        = LOAD;
      end
      LOAD: begin
        shift_n = fifo.fifo_rd_data;
        div_n   = '0;
        state_n = START;
      end
      START: begin
        tx_serial = 1'b0;
        if (bit_end) begin
          div_n   = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          div_n = div + 8'd1;
        end
      end
      DATA: begin
        tx_serial = shift[0];
        if (bit_end) begin
          div_n   = '0;
          shift_n = shift >> 1;
          if (bit_cnt == LAST_BIT)
            state_n = STOP;
          else
            bit_n = bit_cnt + BW'(1);
        end else begin
          div_n = div + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          div_n   = '0;
          count_n = word_count + 8'd1;
          state_n = IDLE;
        end else begin
          div_n = div + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Randomized bench for fifo_serial_tx with a frame-schedule model.
// Bench FIFO feeds the DUT; every output is compared each cycle.
module tb_fifo_serial_tx;
  localparam int DW  = 16;
  localparam int CPB = 4;
  localparam int LEN = 2 + (DW + 2) * CPB;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          tx_enable = 1'b0;
  logic          tx_serial;
  logic          tx_busy;
  logic [7:0]    word_count;

  fifo_serial_tx_if #(.DATA_WIDTH(DW)) ifc ();

  fifo_serial_tx #(
    .DATA_WIDTH(DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_(rst_),
    .fifo(ifc.master),
    .tx_enable(tx_enable),
    .tx_serial(tx_serial),
    .tx_busy(tx_busy),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_int(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s: got %0h want %0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  // Bench FIFO: pops on fifo_read, data held through LOAD,
  // garbage otherwise so stray captures show up.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] mq[$];
  bit            hold = 1'b0;

  always @(negedge clk) begin
    if (ifc.fifo_read) begin
      check_int("pop_nonempty", int'(fq.size() > 0), 1);
      if (fq.size() > 0)
        ifc.fifo_rd_data = fq.pop_front();
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      ifc.fifo_rd_data = DW'($urandom);
    end
    ifc.fifo_empty = (fq.size() == 0);
  end

  task automatic push(logic [DW-1:0] w);
    fq.push_back(w);
    mq.push_back(w);
    ifc.fifo_empty = 1'b0;
  endtask

  // Model: k = cycles since the POP cycle, -1 when idle.
  int            k = -1;
  logic [DW-1:0] mw = '0;
  int            exp_cnt = 0;
  int            cyc = 0;
  int            pulses = 0;
  int            last_pulse = -1;
  int            gaps[$];
  logic [DW-1:0] rx = '0;
  logic [DW-1:0] last_rx = '0;
  bit            any_busy = 1'b0;
  bit            any_low = 1'b0;

  function automatic logic exp_line(int kk, logic [DW-1:0] w);
    int j;
    if (kk < 2) return 1'b1;
    j = (kk - 2) / CPB;
    if (j == 0) return 1'b0;
    if (j <= DW) return w[j-1];
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    int j, b;
    cyc++;
    if (!rst_) begin
      k = -1;
      exp_cnt = 0;
    end else if (k < 0) begin
      if (tx_enable && !ifc.fifo_empty) begin
        k = 0;
        mw = mq.pop_front();
      end
    end else begin
      k++;
      if (k == LEN) begin
        k = -1;
        exp_cnt = (exp_cnt + 1) % 256;
      end
    end
    #1;
    if (rst_) begin
      check_int("fifo_read", int'(ifc.fifo_read), int'(k == 0));
      check_int("tx_busy", int'(tx_busy), int'(k >= 0));
      check_int("tx_serial", int'(tx_serial),
                int'(exp_line(k, mw)));
      check_int("word_count", int'(word_count), exp_cnt);
      if (ifc.fifo_read) begin
        pulses++;
        if (last_pulse >= 0) gaps.push_back(cyc - last_pulse);
        last_pulse = cyc;
      end
      if (tx_busy) any_busy = 1'b1;
      if (!tx_serial) any_low = 1'b1;
      if (k >= 2) begin
        j = k - 2;
        b = j / CPB;
        if (j % CPB == CPB / 2) begin
          if (b >= 1 && b <= DW) rx[b-1] = tx_serial;
          if (b == DW + 1) last_rx = rx;
        end
      end
    end
  end

  task automatic wait_done(int budget);
    repeat (2) @(negedge clk);
    for (int i = 0; i < budget; i++) begin
      if (k < 0 && (mq.size() == 0 || !tx_enable)) return;
      @(negedge clk);
    end
    check_int("wait_done_timeout", 1, 0);
  endtask

  task automatic wait_k(int t, int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (k == t) return;
    end
    check_int("wait_k_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    ifc.fifo_empty   = 1'b1;
    ifc.fifo_rd_data = '0;
    repeat (3) @(negedge clk);
    check_int("rst_serial", int'(tx_serial), 1);
    check_int("rst_read", int'(ifc.fifo_read), 0);
    check_int("rst_busy", int'(tx_busy), 0);
    check_int("rst_count", int'(word_count), 0);
    rst_ = 1'b1;

    @(negedge clk);
    pulses = 0;
    push(16'hA5C3);
    tx_enable = 1'b1;
    wait_done(400);
    check_int("single_pulses", pulses, 1);
    check_int("single_count", int'(word_count), 1);
    check_int("single_rx", int'(last_rx), 16'hA5C3);

    pulses = 0;
    gaps.delete();
    last_pulse = -1;
    push(16'h0001);
    push(16'h8000);
    push(16'hFFFF);
    wait_done(600);
    check_int("b2b_pulses", pulses, 3);
    check_int("b2b_ngaps", gaps.size(), 2);
    if (gaps.size() == 2) begin
      check_int("b2b_gap0", gaps[0], 75);
      check_int("b2b_gap1", gaps[1], 75);
    end
    check_int("b2b_count", int'(word_count), 4);
    check_int("b2b_rx", int'(last_rx), 16'hFFFF);
    any_low = 1'b0;
    repeat (50) @(negedge clk);
    check_int("b2b_line_high", int'(any_low), 0);

    pulses = 0;
    any_busy = 1'b0;
    any_low = 1'b0;
    repeat (200) @(negedge clk);
    check_int("empty_pulses", pulses, 0);
    check_int("empty_busy", int'(any_busy), 0);
    check_int("empty_low", int'(any_low), 0);
    tx_enable = 1'b0;
    push(16'h1357);
    repeat (200) @(negedge clk);
    check_int("dis_pulses", pulses, 0);
    check_int("dis_busy", int'(any_busy), 0);
    check_int("dis_low", int'(any_low), 0);

    push(16'h2468);
    tx_enable = 1'b1;
    wait_k(2 + CPB * 6, 200);
    tx_enable = 1'b0;
    wait_done(200);
    repeat (100) @(negedge clk);
    check_int("mid_pulses", pulses, 1);
    check_int("mid_count", int'(word_count), 5);
    check_int("mid_rx", int'(last_rx), 16'h1357);
    tx_enable = 1'b1;
    wait_done(300);
    check_int("reen_pulses", pulses, 2);
    check_int("reen_count", int'(word_count), 6);
    check_int("reen_rx", int'(last_rx), 16'h2468);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) push(DW'($urandom));
      if ($urandom_range(0, 59) == 0) tx_enable = ~tx_enable;
    end
    tx_enable = 1'b1;
    wait_done(6000);

    do_reset();
    pulses = 0;
    for (int i = 0; i < 256; i++) push(DW'($urandom));
    wait_done(256 * 75 + 300);
    check_int("wrap_pulses", pulses, 256);
    check_int("wrap_count", int'(word_count), 0);

    pulses = 0;
    push(16'h1234);
    push(16'hBEEF);
    wait_k(2 + CPB * 4 + 1, 200);
    check_int("pre_rst_line", int'(tx_serial), 0);
    #2 rst_ = 1'b0;
    #1;
    check_int("arst_serial", int'(tx_serial), 1);
    check_int("arst_read", int'(ifc.fifo_read), 0);
    check_int("arst_busy", int'(tx_busy), 0);
    check_int("arst_count", int'(word_count), 0);
    @(negedge clk);
    rst_ = 1'b1;
    wait_done(300);
    check_int("arst_next_rx", int'(last_rx), 16'hBEEF);
    check_int("arst_next_count", int'(word_count), 1);
    check_int("arst_pulses", pulses, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

FIFO drain and serial transmit engine for the read side of the 16x16 synchronous FIFO. When enabled and the FIFO is not empty, it pops one word and transmits it on a single wire as an asynchronous serial frame: start bit, DATA_WIDTH data bits LSB first, stop bit. It repeats until the FIFO is empty or transmission is disabled. It is the only reader of its FIFO instance.

## Interface
- DATA_WIDTH, 16: FIFO word width and data bits per frame.
- CLKS_PER_BIT, 4: clk cycles per serial bit; legal range 2..255.
- clk  in  1  clock; all logic on the rising edge.
- rst_  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DATA_WIDTH  FIFO registered read data; valid the cycle after a cycle with fifo_read=1.
- tx_enable  in  1  permits new frames to start; sampled only in IDLE.
- fifo_read  out  1  one-cycle pop strobe to the FIFO.
- tx_serial  out  1  serial line; idles high.
- tx_busy  out  1  high whenever state is not IDLE.
- word_count  out  8  count of completed frames; wraps 255->0.

## Operation
- States: IDLE, POP, LOAD, START, DATA, STOP. The state register, shift register, bit counter ($clog2(DATA_WIDTH) bits), clock-divider counter (8 bits) and word_count are all reset asynchronously.
- Reset values:
  - state = IDLE
  - fifo_read = 0
  - tx_serial = 1
  - tx_busy = 0
  - word_count = 0
  - shift register = 0
  - both counters = 0
- IDLE: tx_serial = 1. If tx_enable && !fifo_empty, go to POP. Otherwise stay in IDLE.
- POP: fifo_read = 1 for this one cycle only; tx_serial = 1. Go to LOAD.
- LOAD: fifo_rd_data is valid. Capture it into the shift register at the end of the cycle; tx_serial = 1. Go to START.
- START: tx_serial = 0 for CLKS_PER_BIT cycles, then go to DATA with the bit counter = 0.
- DATA: tx_serial = shift[0]. Each bit is held for CLKS_PER_BIT cycles, then the register shifts right. After bit DATA_WIDTH-1, go to STOP.
- STOP: tx_serial = 1 for CLKS_PER_BIT cycles. At the end of STOP, word_count increments (mod 256) and the state returns to IDLE.
- fifo_read is a decoded state output (state==POP). It is never asserted while fifo_empty was 1 at the IDLE decision. This is safe because no other reader exists, so the FIFO cannot become empty between IDLE and POP.
- A tx_enable deassertion after leaving IDLE has no effect on the current frame. The frame always completes, and no further pop occurs until tx_enable is 1 again in IDLE.
- A FIFO write during a frame has no effect until the next IDLE evaluation.
- fifo_rd_data is ignored in every state except LOAD.

## Timing
- Let edge E be the edge at which IDLE samples tx_enable=1 and fifo_empty=0.
  - fifo_read is high in the cycle E..E+1.
  - Data is captured at E+2.
  - The start bit begins at E+2.
- Frame length is (DATA_WIDTH+2)*CLKS_PER_BIT cycles: 72 with the defaults.
- Word period with continuous enable and a non-empty FIFO is 3 + (DATA_WIDTH+2)*CLKS_PER_BIT cycles: 75 with the defaults.
- There is exactly one IDLE cycle (tx_serial=1) between the end of the stop bit and the next POP.
- word_count updates on the same edge that leaves STOP.
- Reset mid-frame:
  - tx_serial goes to 1 and fifo_read to 0 immediately (asynchronously).
  - The frame is abandoned. The popped word is lost; no replay.
- tx_busy is high from the edge entering POP through the edge leaving STOP.

## Test plan
- Reset: assert rst_=0 mid-sim -> tx_serial=1, fifo_read=0, tx_busy=0, word_count=0 with no clock edge required.
- Single word: FIFO holds 16'hA5C3, tx_enable=1, CLKS_PER_BIT=4 -> exactly one fifo_read pulse, then the line pattern below, with each bit held 4 cycles:
  - 0 (start)
  - 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (data, LSB first)
  - 1 (stop)
  - word_count=1; the bench deserializer recovers 16'hA5C3.
- Back-to-back: write 16'h0001, 16'h8000, 16'hFFFF -> three frames in order, fifo_read pulses exactly 75 cycles apart, FIFO empty after the third POP, word_count=3, line held high afterwards.
- Empty / disabled: fifo_empty=1 with tx_enable=1, and separately a non-empty FIFO with tx_enable=0 -> no fifo_read for 200 cycles, tx_serial constantly 1, tx_busy=0.
- Disable mid-frame: drop tx_enable during DATA bit 5 with 2 words queued -> the current frame completes correctly, no second pop, word_count=1. Re-enabling sends the second word.
- Wrap and reset mid-frame:
  - Stream 256 words -> word_count returns to 0.
  - Pulse rst_ low during a DATA bit -> line high immediately; after release, the next frame starts with the following FIFO word.
